// File: rtl/plot_arbiter.sv
// plot_arbiter: shares the single VGA adapter pixel-write port among
// NUM_REQ drawing requesters (screen fill, player sprite, enemy sprites).
// A round-robin arbiter grants one requester at a time. The grant is held
// until that requester pulses done, drops req, or exceeds MAX_HOLD cycles.
// The granted requester's pixel is forwarded through one register stage.
//
// Ports:
//   clock      - system clock, rising edge
//   reset      - synchronous active-low reset
//   req        - per-requester request (level-held)
//   done       - per-requester completion pulse (only granted bit honoured)
//   plot_in    - per-requester pixel write enable
//   x_in/y_in/colour_in - packed per-requester pixel data, requester 0 in LSBs
//   grant      - registered one-hot grant, zero when nobody is granted
//   vga_plot/vga_x/vga_y/vga_colour - registered pixel write to the VGA adapter
//   overrun    - one-cycle pulse when a grant is force-released by timeout
//   busy       - high while a grant is active
module plot_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int MAX_HOLD = 19200
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            done,
  input  logic [NUM_REQ-1:0]            plot_in,
  input  logic [NUM_REQ*X_W-1:0]        x_in,
  input  logic [NUM_REQ*Y_W-1:0]        y_in,
  input  logic [NUM_REQ*COLOUR_W-1:0]   colour_in,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          vga_plot,
  output logic [X_W-1:0]                vga_x,
  output logic [Y_W-1:0]                vga_y,
  output logic [COLOUR_W-1:0]           vga_colour,
  output logic                          overrun,
  output logic                          busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]      gidx_q, gidx_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  vga_plot_q, vga_plot_d;
  logic [X_W-1:0]        vga_x_q, vga_x_d;
  logic [Y_W-1:0]        vga_y_q, vga_y_d;
  logic [COLOUR_W-1:0]   vga_colour_q, vga_colour_d;
  logic                  overrun_q, overrun_d;

  logic                  sel_found_s;
  logic [IDX_W-1:0]      sel_idx_s;
  logic [IDX_W-1:0]      cand_s;
  logic                  g_plot_s;
  logic [X_W-1:0]        g_x_s;
  logic [Y_W-1:0]        g_y_s;
  logic [COLOUR_W-1:0]   g_colour_s;
  logic                  g_done_s;
  logic                  g_req_s;
  logic                  timeout_s;

  // Round-robin pick: first requesting index after the last-served one.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = {IDX_W{1'b0}};
    cand_s      = {IDX_W{1'b0}};
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s = IDX_W'((int'(last_q) + i) % NUM_REQ);
      if (!sel_found_s && req[cand_s]) begin
        sel_found_s = 1'b1;
        sel_idx_s   = cand_s;
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Mux out the granted requester's pixel data and control bits.
  always_comb begin
    g_plot_s   = 1'b0;
    g_x_s      = {X_W{1'b0}};
    g_y_s      = {Y_W{1'b0}};
    g_colour_s = {COLOUR_W{1'b0}};
    g_done_s   = 1'b0;
    g_req_s    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx_q == IDX_W'(i)) begin
        g_plot_s   = plot_in[i];
        g_x_s      = x_in[i*X_W +: X_W];
        g_y_s      = y_in[i*Y_W +: Y_W];
        g_colour_s = colour_in[i*COLOUR_W +: COLOUR_W];
        g_done_s   = done[i];
        g_req_s    = req[i];
      end else begin
        g_plot_s = g_plot_s;
      end
    end
    timeout_s = (cnt_q == CNT_W'(MAX_HOLD - 1));
  end

  // Next-state and next-output logic for the IDLE/BUSY/GAP sequence.
  always_comb begin
    state_d      = state_q;
    grant_d      = {NUM_REQ{1'b0}};
    gidx_d       = gidx_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    vga_plot_d   = 1'b0;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    overrun_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_found_s) begin
          state_d = BUSY;
          grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx_s;
          gidx_d  = sel_idx_s;
          last_d  = sel_idx_s;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        // Counter saturates at MAX_HOLD so it can never wrap.
        if (cnt_q != CNT_W'(MAX_HOLD)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
        if (g_done_s || !g_req_s || timeout_s) begin
          state_d = GAP;
          // Overrun only when the timeout alone ended the grant.
          overrun_d = !g_done_s && g_req_s;
        end else begin
          grant_d      = grant_q;
          vga_plot_d   = g_plot_s;
          vga_x_d      = g_x_s;
          vga_y_d      = g_y_s;
          vga_colour_d = g_colour_s;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= {NUM_REQ{1'b0}};
      gidx_q       <= {IDX_W{1'b0}};
      last_q       <= IDX_W'(NUM_REQ - 1);
      cnt_q        <= {CNT_W{1'b0}};
      vga_plot_q   <= 1'b0;
      vga_x_q      <= {X_W{1'b0}};
      vga_y_q      <= {Y_W{1'b0}};
      vga_colour_q <= {COLOUR_W{1'b0}};
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      gidx_q       <= gidx_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      vga_plot_q   <= vga_plot_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      overrun_q    <= overrun_d;
    end
  end

  assign grant      = grant_q;
  assign vga_plot   = vga_plot_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q == BUSY);

endmodule

// File: tb/tb_plot_arbiter.sv
// Self-checking bench for plot_arbiter (NUM_REQ=4, MAX_HOLD=8).
// Directed steps follow the block's intended scenarios, then a randomized
// phase; every cycle is compared against a behavioural model.
module tb_plot_arbiter;
  localparam int N  = 4;
  localparam int MH = 8;

  logic          clock;
  logic          reset;
  logic [N-1:0]  req, done, plot_in;
  logic [N*8-1:0] x_in;
  logic [N*7-1:0] y_in;
  logic [N*3-1:0] colour_in;
  logic [N-1:0]  grant;
  logic          vga_plot;
  logic [7:0]    vga_x;
  logic [6:0]    vga_y;
  logic [2:0]    vga_colour;
  logic          overrun;
  logic          busy;

  int errors = 0;
  int checks = 0;

  // behavioural model: phase 0=idle, 1=granted, 2=gap
  int m_phase, m_owner, m_last, m_held;
  logic [N-1:0] e_grant;
  logic         e_plot, e_ovr;
  logic [7:0]   e_x;
  logic [6:0]   e_y;
  logic [2:0]   e_col;

  plot_arbiter #(.NUM_REQ(N), .X_W(8), .Y_W(7), .COLOUR_W(3), .MAX_HOLD(MH)) dut (
    .clock(clock), .reset(reset), .req(req), .done(done), .plot_in(plot_in),
    .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .grant(grant),
    .vga_plot(vga_plot), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .overrun(overrun), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_update();
    int c;
    int g;
    int held;
    if (!reset) begin
      m_phase = 0; m_last = N - 1; m_held = 0; m_owner = 0;
      e_grant = '0; e_plot = 1'b0; e_x = '0; e_y = '0; e_col = '0; e_ovr = 1'b0;
    end else if (m_phase == 0) begin
      e_plot = 1'b0; e_ovr = 1'b0; e_grant = '0;
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (m_phase == 0 && req[c]) begin
          m_owner = c; m_last = c; m_phase = 1; m_held = 0;
          e_grant = 4'b0001 << c;
        end
      end
    end else if (m_phase == 1) begin
      g = m_owner;
      held = m_held + 1;
      if (done[g] || !req[g] || held >= MH) begin
        e_ovr = !done[g] && req[g];
        m_phase = 2; e_grant = '0; e_plot = 1'b0;
      end else begin
        m_held = held;
        e_plot = plot_in[g];
        e_x = x_in[g*8 +: 8];
        e_y = y_in[g*7 +: 7];
        e_col = colour_in[g*3 +: 3];
        e_ovr = 1'b0;
      end
    end else begin
      m_phase = 0; e_grant = '0; e_plot = 1'b0; e_ovr = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("grant", grant, e_grant);
    chk("vga_plot", vga_plot, e_plot);
    chk("vga_x", vga_x, e_x);
    chk("vga_y", vga_y, e_y);
    chk("vga_colour", vga_colour, e_col);
    chk("overrun", overrun, e_ovr);
    chk("busy", busy, (m_phase == 1));
  endtask

  task automatic tick();
    model_update();
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    while (grant == 4'b0000 && n < 20) begin
      tick();
      n++;
    end
    chk("wait_grant", (grant != 4'b0000), 1'b1);
  endtask

  initial begin
    int zeros;
    int held;
    int ovr_cnt;
    reset = 1'b0; req = '0; done = '0; plot_in = '0;
    x_in = '0; y_in = '0; colour_in = '0;
    tick(); tick();
    chk("reset_grant", grant, 4'b0000);
    chk("reset_plot", vga_plot, 1'b0);

    // Single requester, one pixel, done pulse.
    reset = 1'b1; req = 4'b0001; plot_in = 4'b0001;
    x_in[7:0] = 8'd10; y_in[6:0] = 7'd20; colour_in[2:0] = 3'd3;
    tick();
    chk("t1_grant", grant, 4'b0001);
    tick();
    chk("t1_plot", vga_plot, 1'b1);
    chk("t1_x", vga_x, 8'd10);
    chk("t1_y", vga_y, 7'd20);
    chk("t1_col", vga_colour, 3'd3);
    done = 4'b0001; req = 4'b0000;
    tick();
    done = '0;
    chk("t1_gap_grant", grant, 4'b0000);
    chk("t1_gap_plot", vga_plot, 1'b0);
    tick();

    // All request, round-robin order with two idle cycles between grants.
    reset = 1'b0; tick();
    reset = 1'b1; req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_grant(zeros);
      if (n > 0) chk("rr_gap", zeros, 2);
      chk("rr_grant", grant, 4'b0001 << (n % 4));
      tick(); tick();
      done = grant;
      if (n == 4) req = 4'b0000;
      tick();
      done = '0;
    end
    tick(); tick();

    // Requester 2 drops req without done; pending 3 goes next.
    req = 4'b1100;
    wait_grant(zeros);
    chk("drop_grant2", grant, 4'b0100);
    tick();
    req = 4'b1000;
    tick();
    chk("drop_release", grant, 4'b0000);
    chk("drop_no_ovr", overrun, 1'b0);
    wait_grant(zeros);
    chk("drop_grant3", grant, 4'b1000);
    req = 4'b0000;
    tick(); tick(); tick();

    // Requester 1 holds past MAX_HOLD.
    req = 4'b0010;
    wait_grant(zeros);
    chk("to_grant1", grant, 4'b0010);
    req = 4'b0011;
    held = 1; ovr_cnt = 0;
    for (int n = 0; n < 30 && grant != 4'b0001; n++) begin
      tick();
      if (grant == 4'b0010) held++;
      if (overrun) ovr_cnt++;
    end
    chk("to_held", held, MH);
    chk("to_ovr_once", ovr_cnt, 1);
    chk("to_next", grant, 4'b0001);
    done = 4'b0001; req = 4'b0000;
    tick();
    done = '0;
    tick(); tick();

    // done coincides with timeout: no overrun.
    req = 4'b0100;
    wait_grant(zeros);
    chk("dt_grant", grant, 4'b0100);
    for (int n = 0; n < MH - 1; n++) tick();
    done = 4'b0100;
    tick();
    done = '0;
    chk("dt_release", grant, 4'b0000);
    chk("dt_no_ovr", overrun, 1'b0);
    req = '0;
    tick(); tick();

    // done from a non-granted requester is ignored.
    req = 4'b0001;
    wait_grant(zeros);
    done = 4'b1000;
    tick();
    done = '0;
    chk("foreign_done", grant, 4'b0001);
    req = '0;
    tick(); tick(); tick();

    // Reset mid-grant.
    req = 4'b0010; plot_in = 4'b0010;
    wait_grant(zeros);
    tick();
    chk("mr_plot", vga_plot, 1'b1);
    reset = 1'b0;
    tick();
    chk("mr_grant", grant, 4'b0000);
    chk("mr_plot0", vga_plot, 1'b0);
    chk("mr_x0", vga_x, 8'd0);
    reset = 1'b1; req = 4'b0011;
    tick();
    chk("mr_first", grant, 4'b0001);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      done = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      plot_in = 4'($urandom);
      x_in = 32'($urandom);
      y_in = 28'($urandom);
      colour_in = 12'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
